// File: rtl/ecc_key_import_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ecc_key_import_ctrl
// Description : Imports an EC private scalar d as a big-endian byte stream.
//               It checks the length and checks that 0 < d < n. It then runs
//               the shared point multiplier to derive Q = d*G, and streams
//               the uncompressed public key 0x04 || X || Y.
// Ports       : clk, rst            - clock, async active-high reset
//               start               - begin import (IDLE/DONE/ERR only)
//               curve_order         - group order n
//               in_valid/ready/data/last  - scalar byte input, MSB first
//               mul_start/scalar    - multiplier request
//               mul_done/err/x/y    - multiplier response
//               out_valid/ready/data/last - public key byte output
//               busy, done, err_code      - status
//                 err_code: 0 none, 1 LEN, 2 RANGE, 3 MULT
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_key_import_ctrl #(
    parameter int KEY_BYTES = 32,
    parameter int CW        = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] curve_order,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   mul_start,
    output logic [8*KEY_BYTES-1:0] mul_scalar,
    input  logic                   mul_done,
    input  logic                   mul_err,
    input  logic [8*KEY_BYTES-1:0] mul_x,
    input  logic [8*KEY_BYTES-1:0] mul_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err_code
);

    localparam int c_KW = 8 * KEY_BYTES;            // scalar / coordinate width
    localparam int c_OW = 8 * (2 * KEY_BYTES + 1);  // full public key width

    localparam logic [CW-1:0] c_KEY_CNT  = CW'(KEY_BYTES);
    localparam logic [CW-1:0] c_LAST_CNT = CW'(2 * KEY_BYTES);

    localparam logic [1:0] c_ERR_NONE  = 2'd0;
    localparam logic [1:0] c_ERR_LEN   = 2'd1;
    localparam logic [1:0] c_ERR_RANGE = 2'd2;
    localparam logic [1:0] c_ERR_MULT  = 2'd3;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_CHECK = 3'd3;
    localparam logic [2:0] c_ST_MULT  = 3'd4;
    localparam logic [2:0] c_ST_EMIT  = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;
    localparam logic [2:0] c_ST_ERR   = 3'd7;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_KW-1:0] r_scalar;
    logic [c_OW-1:0] r_obuf;      // 0x04||X||Y, shifted out MSB first
    logic [CW-1:0]   r_cnt;       // bytes loaded in LOAD, byte index in EMIT
    logic [1:0]      r_err;
    logic            r_mul_start;

    logic [CW-1:0]   w_cnt_inc;
    logic            w_key_full;
    logic            w_range_bad;
    logic            w_idle_like;
    logic            w_emit_last;

    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_key_full  = (w_cnt_inc == c_KEY_CNT);
    assign w_range_bad = (r_scalar == '0) || (r_scalar >= curve_order);
    assign w_idle_like = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                         (r_state == c_ST_ERR);
    assign w_emit_last = (r_cnt == c_LAST_CNT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_ERR: begin
                if (start) w_state_nxt = c_ST_LOAD;
            end
            c_ST_DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (in_last) begin
                        w_state_nxt = w_key_full ? c_ST_CHECK : c_ST_ERR;
                    end else if (w_key_full) begin
                        // Too long: swallow the rest of the frame first.
                        w_state_nxt = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && in_last) w_state_nxt = c_ST_ERR;
            end
            c_ST_CHECK: begin
                busy        = 1'b1;
                w_state_nxt = w_range_bad ? c_ST_ERR : c_ST_MULT;
            end
            c_ST_MULT: begin
                busy = 1'b1;
                // A fault takes priority over a simultaneous result.
                if (mul_err) begin
                    w_state_nxt = c_ST_ERR;
                end else if (mul_done) begin
                    w_state_nxt = c_ST_EMIT;
                end
            end
            c_ST_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = w_emit_last;
                if (out_ready && w_emit_last) w_state_nxt = c_ST_DONE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: scalar gathering, result latch, output shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scalar    <= '0;
            r_obuf      <= '0;
            r_cnt       <= '0;
            r_err       <= c_ERR_NONE;
            r_mul_start <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    if (in_valid) begin
                        r_scalar <= {r_scalar[c_KW-9:0], in_data};
                        r_cnt    <= w_cnt_inc;
                        if (in_last && !w_key_full) begin
                            r_err    <= c_ERR_LEN;
                            r_scalar <= '0;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (in_valid && in_last) begin
                        r_err    <= c_ERR_LEN;
                        r_scalar <= '0;
                    end
                end
                c_ST_CHECK: begin
                    if (w_range_bad) begin
                        r_err    <= c_ERR_RANGE;
                        r_scalar <= '0;
                    end else begin
                        r_mul_start <= 1'b1;
                    end
                end
                c_ST_MULT: begin
                    if (mul_err) begin
                        r_err    <= c_ERR_MULT;
                        r_scalar <= '0;
                    end else if (mul_done) begin
                        r_obuf   <= {8'h04, mul_x, mul_y};
                        r_scalar <= '0;
                        r_cnt    <= '0;
                    end
                end
                c_ST_EMIT: begin
                    if (out_ready) begin
                        r_obuf <= {r_obuf[c_OW-9:0], 8'h00};
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_emit_last) r_obuf <= '0;
                    end
                end
                default: begin
                    if (w_idle_like && start) begin
                        r_scalar <= '0;
                        r_obuf   <= '0;
                        r_cnt    <= '0;
                        r_err    <= c_ERR_NONE;
                    end
                end
            endcase
        end
    end

    assign mul_start  = r_mul_start;
    // The scalar is only exposed while the multiplier is working on it.
    assign mul_scalar = (r_state == c_ST_MULT) ? r_scalar : '0;
    assign out_data   = (r_state == c_ST_EMIT) ? r_obuf[c_OW-1 -: 8] : 8'h00;
    assign err_code   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ecc_key_import_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_key_import_ctrl
// Description : Directed self-checking bench for ecc_key_import_ctrl.
//               It covers the nominal import and emit, the short and long
//               scalar cases, range rejection, multiplier fault priority,
//               output stalls and asynchronous reset during emit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_key_import_ctrl;

    localparam int KEY_BYTES = 32;
    localparam int CW        = 7;

    localparam logic [255:0] c_ORDER =
        256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;
    localparam logic [255:0] c_ORDER_M1 =
        256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632550;
    localparam logic [255:0] c_KEY1 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] curve_order = c_ORDER;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         mul_start;
    logic [255:0] mul_scalar;
    logic         mul_done = 1'b0;
    logic         mul_err = 1'b0;
    logic [255:0] mul_x = '0;
    logic [255:0] mul_y = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic         done;
    logic [1:0]   err_code;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_mul_start = 0;

    ecc_key_import_ctrl #(.KEY_BYTES(KEY_BYTES), .CW(CW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .curve_order (curve_order),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .mul_start   (mul_start),
        .mul_scalar  (mul_scalar),
        .mul_done    (mul_done),
        .mul_err     (mul_err),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mul_start) n_mul_start++;
    end

    task automatic check_val(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bytes 0..31 come from v (MSB first); any further bytes are filler.
    task automatic send_vec(input logic [255:0] v, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = (i < 32) ? v[255-8*i -: 8] : 8'(8'hC0 + i);
            in_last  = last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Public key byte idx: 0x04, then X = 0x40.., then Y = 0x80..
    function automatic logic [7:0] pk_byte(input int idx);
        if (idx == 0) return 8'h04;
        else if (idx <= 32) return 8'(8'h40 + idx - 1);
        else return 8'(8'h80 + idx - 33);
    endfunction

    task automatic give_result();
        for (int i = 0; i < 32; i++) begin
            mul_x[255-8*i -: 8] = 8'(8'h40 + i);
            mul_y[255-8*i -: 8] = 8'(8'h80 + i);
        end
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_in_ready",  in_ready,   0);
        check_val("rst_mul_start", mul_start,  0);
        check_val("rst_mul_scal",  mul_scalar, 0);
        check_val("rst_out_valid", out_valid,  0);
        check_val("rst_out_data",  out_data,   0);
        check_val("rst_out_last",  out_last,   0);
        check_val("rst_busy",      busy,       0);
        check_val("rst_done",      done,       0);
        check_val("rst_err",       err_code,   0);
        rst = 1'b0;
        tick();
        check_val("idle_in_ready", in_ready, 0);

        // ---------------- 1: nominal import ----------------
        do_start();
        check_val("t1_load_ready", in_ready, 1);
        check_val("t1_load_busy",  busy,     1);
        send_vec(c_KEY1, 32, 1'b1);
        check_val("t1_check_ready", in_ready,  0);
        check_val("t1_check_mstart", mul_start, 0);
        tick();
        check_val("t1_mul_start",  mul_start,  1);
        check_val("t1_mul_scalar", mul_scalar, c_KEY1);
        give_result();
        check_val("t1_pulse_end",   mul_start,  0);
        check_val("t1_scalar_zero", mul_scalar, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 65; k++) begin
            check_val("t1_out_valid", out_valid, 1);
            check_val("t1_out_data",  out_data,  pk_byte(k));
            check_val("t1_out_last",  out_last,  (k == 64) ? 1 : 0);
            tick();
        end
        out_ready = 1'b0;
        check_val("t1_done",      done,        1);
        check_val("t1_err",       err_code,    0);
        check_val("t1_busy",      busy,        0);
        check_val("t1_out_idle",  out_valid,   0);
        check_val("t1_mstart_n",  n_mul_start, 1);

        // ---------------- 2: short scalar ----------------
        do_start();
        check_val("t2_done_clr", done, 0);
        send_vec(c_KEY1, 31, 1'b1);
        check_val("t2_ready_drop", in_ready,    0);
        check_val("t2_err_len",    err_code,    1);
        check_val("t2_busy",       busy,        0);
        check_val("t2_no_mstart",  n_mul_start, 1);

        // ---------------- 3: long scalar ----------------
        do_start();
        check_val("t3_err_clr", err_code, 0);
        send_vec(c_KEY1, 32, 1'b0);
        check_val("t3_drain_ready", in_ready, 1);
        check_val("t3_drain_err",   err_code, 0);
        check_val("t3_drain_busy",  busy,     1);
        send_vec(c_KEY1, 8, 1'b1);
        check_val("t3_err_len",    err_code,    1);
        check_val("t3_ready_drop", in_ready,    0);
        check_val("t3_no_mstart",  n_mul_start, 1);

        // ---------------- 4: range checks ----------------
        do_start();
        send_vec('0, 32, 1'b1);
        tick();
        check_val("t4_zero_err", err_code, 2);
        do_start();
        send_vec(c_ORDER, 32, 1'b1);
        tick();
        check_val("t4_eq_n_err",  err_code,    2);
        check_val("t4_no_mstart", n_mul_start, 1);
        do_start();
        send_vec(c_ORDER_M1, 32, 1'b1);
        tick();
        check_val("t4_nm1_mstart", mul_start,  1);
        check_val("t4_nm1_scalar", mul_scalar, c_ORDER_M1);
        check_val("t4_nm1_err",    err_code,   0);

        // ---------------- 5: fault wins over result ----------------
        mul_err  = 1'b1;
        mul_done = 1'b1;
        tick();
        mul_err  = 1'b0;
        mul_done = 1'b0;
        check_val("t5_err_mult",  err_code,   3);
        check_val("t5_no_out",    out_valid,  0);
        check_val("t5_scal_zero", mul_scalar, 0);
        check_val("t5_busy",      busy,       0);
        tick();
        check_val("t5_no_out2",   out_valid,  0);

        // ---------------- 6: stalls and reset mid-emit ----------------
        do_start();
        send_vec(c_KEY1, 32, 1'b1);
        tick();
        give_result();
        begin
            int idx = 0;
            for (int c = 0; c < 10; c++) begin
                out_ready = (c % 2 == 0);
                check_val("t6_out_valid", out_valid, 1);
                check_val("t6_out_data",  out_data,  pk_byte(idx));
                tick();
                if (out_ready) idx++;
            end
            check_val("t6_stall_data", out_data, pk_byte(idx));
        end
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_rst_out_valid", out_valid,  0);
        check_val("t6_rst_out_data",  out_data,   0);
        check_val("t6_rst_out_last",  out_last,   0);
        check_val("t6_rst_busy",      busy,       0);
        check_val("t6_rst_in_ready",  in_ready,   0);
        check_val("t6_rst_done",      done,       0);
        check_val("t6_rst_err",       err_code,   0);
        check_val("t6_rst_mscalar",   mul_scalar, 0);
        tick();
        rst = 1'b0;
        tick();
        check_val("t6_idle_busy",  busy,      0);
        check_val("t6_idle_out",   out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
